mux_bit_sequencer: RTL and testbench

//  Upstream driver for the 8:1 bit-select mux stage (DATA_IN/S/EN_0 -> DATA_OUT).

---
 rtl/mux_bit_sequencer.sv | 122 ++++++++++++
 tb/tb_mux_bit_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mux_bit_sequencer.sv
// Upstream driver for an 8:1 bit-select mux: latches a byte on a valid/ready handshake,
// then walks the select through all 8 positions, holding each for BIT_CYCLES clocks.
module mux_bit_sequencer #(
  parameter int BIT_CYCLES = 4,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] data_in,
  output logic [2:0] s,
  output logic       en_0,
  output logic       bit_strobe,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] CYC_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [2:0] S_FIRST  = MSB_FIRST ? 3'd7 : 3'd0;

  state_t     state, state_nxt;
  logic [7:0] cyc_cnt, cyc_cnt_nxt;
  logic [7:0] gap_cnt, gap_cnt_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       in_ready_nxt, en_0_nxt, bit_strobe_nxt, done_nxt;
  logic [7:0] data_in_nxt;
  logic [2:0] s_nxt;

  always_comb begin
    state_nxt      = state;
    cyc_cnt_nxt    = cyc_cnt;
    gap_cnt_nxt    = gap_cnt;
    bit_cnt_nxt    = bit_cnt;
    in_ready_nxt   = in_ready;
    data_in_nxt    = data_in;
    s_nxt          = s;
    en_0_nxt       = en_0;
    bit_strobe_nxt = 1'b0;
    done_nxt       = 1'b0;
    case (state)
      IDLE: begin
        in_ready_nxt = 1'b1;
        en_0_nxt     = 1'b0;
        // in_ready is registered, so the first post-reset cycle never accepts
        if (in_valid && in_ready) begin
          data_in_nxt    = in_data;
          s_nxt          = S_FIRST;
          en_0_nxt       = 1'b1;
          bit_strobe_nxt = 1'b1;
          in_ready_nxt   = 1'b0;
          cyc_cnt_nxt    = '0;
          bit_cnt_nxt    = '0;
          state_nxt      = SHIFT;
        end
      end
      SHIFT: begin
        if (cyc_cnt == CYC_LAST) begin
          cyc_cnt_nxt = '0;
          if (bit_cnt == 3'd7) begin
            // last bit done: S and DATA_IN stay put for the mux
            en_0_nxt = 1'b0;
            done_nxt = 1'b1;
            if (GAP_CYCLES == 0) begin
              in_ready_nxt = 1'b1;
              state_nxt    = IDLE;
            end else begin
              gap_cnt_nxt = '0;
              state_nxt   = GAP;
            end
          end else begin
            s_nxt          = MSB_FIRST ? s - 3'd1 : s + 3'd1;
            bit_cnt_nxt    = bit_cnt + 3'd1;
            bit_strobe_nxt = 1'b1;
          end
        end else begin
          cyc_cnt_nxt = cyc_cnt + 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          in_ready_nxt = 1'b1;
          state_nxt    = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      in_ready   <= 1'b0;
      data_in    <= '0;
      s          <= '0;
      en_0       <= 1'b0;
      bit_strobe <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cyc_cnt    <= cyc_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      in_ready   <= in_ready_nxt;
      data_in    <= data_in_nxt;
      s          <= s_nxt;
      en_0       <= en_0_nxt;
      bit_strobe <= bit_strobe_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mux_bit_sequencer.sv
// Bench for mux_bit_sequencer: three configurations (LSB/4clk/no gap, MSB/4clk/gap 3,
// LSB/1clk) driven one at a time; serial bits scoreboarded against the sent byte.
module tb_mux_bit_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] sel;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  logic [2:0] rdy, en, stb, dn, vld;
  logic [7:0] di [3];
  logic [2:0] ss [3];

  logic       o_ready, o_en, o_strobe, o_done;
  logic [7:0] o_data_in;
  logic [2:0] o_s;

  logic       exp_q [$];
  logic [2:0] s_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign vld[0] = in_valid && (sel == 2'd0);
  assign vld[1] = in_valid && (sel == 2'd1);
  assign vld[2] = in_valid && (sel == 2'd2);

  mux_bit_sequencer #(.BIT_CYCLES(4), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(in_data), .in_ready(rdy[0]),
    .data_in(di[0]), .s(ss[0]), .en_0(en[0]), .bit_strobe(stb[0]), .done(dn[0]));
  mux_bit_sequencer #(.BIT_CYCLES(4), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(in_data), .in_ready(rdy[1]),
    .data_in(di[1]), .s(ss[1]), .en_0(en[1]), .bit_strobe(stb[1]), .done(dn[1]));
  mux_bit_sequencer #(.BIT_CYCLES(1), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_data(in_data), .in_ready(rdy[2]),
    .data_in(di[2]), .s(ss[2]), .en_0(en[2]), .bit_strobe(stb[2]), .done(dn[2]));

  always_comb begin
    o_ready = rdy[0]; o_en = en[0]; o_strobe = stb[0]; o_done = dn[0];
    o_data_in = di[0]; o_s = ss[0];
    case (sel)
      2'd1: begin
        o_ready = rdy[1]; o_en = en[1]; o_strobe = stb[1]; o_done = dn[1];
        o_data_in = di[1]; o_s = ss[1];
      end
      2'd2: begin
        o_ready = rdy[2]; o_en = en[2]; o_strobe = stb[2]; o_done = dn[2];
        o_data_in = di[2]; o_s = ss[2];
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one byte on the selected DUT and follows it to its DONE pulse.
  // Returns at the negedge of the DONE cycle; acc is the cycle number of the accept edge.
  task automatic send(input logic [7:0] b, input bit hold, input bit toggle, output int acc);
    int w, n, en_cnt, bc;
    bit msb, got_done, bad_data, overlap;
    logic eb;
    logic [2:0] es;
    bc = (sel == 2'd2) ? 1 : 4;
    msb = (sel == 2'd1);
    w = 0; n = 0; en_cnt = 0; got_done = 0; bad_data = 0; overlap = 0;
    while (o_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    chk("ready_wait", 64'(o_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = b;
    acc = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[msb ? 7 - i : i]);
      s_q.push_back(msb ? 3'(7 - i) : 3'(i));
    end
    while (!got_done && n < 8 * bc + 4) begin
      @(negedge clk);
      n++;
      if (o_en && o_ready) overlap = 1'b1;
      if (o_data_in !== b) bad_data = 1'b1;
      if (o_en) en_cnt++;
      if (o_strobe) begin
        chk("strobe_phase", 64'((n - 1) % bc), 64'd0);
        if (exp_q.size() == 0) chk("extra_strobe", 64'd1, 64'd0);
        else begin
          eb = exp_q.pop_front();
          es = s_q.pop_front();
          chk("s_value", 64'(o_s), 64'(es));
          chk("serial_bit", 64'(o_data_in[o_s]), 64'(eb));
        end
      end
      if (o_done) begin
        got_done = 1'b1;
        chk("done_latency", 64'(n), 64'(8 * bc + 1));
        chk("en_cycles", 64'(en_cnt), 64'(8 * bc));
        chk("en_at_done", 64'(o_en), 64'd0);
        chk("s_at_done", 64'(o_s), msb ? 64'd0 : 64'd7);
        chk("bits_left", 64'(exp_q.size()), 64'd0);
      end else if (toggle) begin
        in_data  = 8'($urandom);
        in_valid = 1'b1;
      end else if (!hold) begin
        in_valid = 1'b0;
      end
    end
    chk("done_seen", 64'(got_done), 64'd1);
    chk("data_held", 64'(bad_data), 64'd0);
    chk("no_en_ready_overlap", 64'(overlap), 64'd0);
    exp_q.delete();
    s_q.delete();
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    int acc1, acc2, m;
    bit bad;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; sel = 2'd0;

    // reset held 3 cycles, then ready the first cycle after release
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", 64'({rdy, en, stb, dn, di[0], di[1], di[2], ss[0], ss[1], ss[2]}), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(rdy), 64'h7);

    // LSB first, 4 clocks per bit
    sel = 2'd0;
    send(8'hA5, 1'b0, 1'b0, acc1);
    @(negedge clk);
    chk("done_single_pulse", 64'(o_done), 64'd0);
    chk("ready_after_done", 64'(o_ready), 64'd1);

    // back-to-back with valid held: minimum byte period
    send(8'h01, 1'b1, 1'b0, acc1);
    send(8'h80, 1'b0, 1'b0, acc2);
    chk("byte_period", 64'(acc2 - acc1), 64'd33);
    @(negedge clk);
    chk("done_single_pulse2", 64'(o_done), 64'd0);

    // reset mid-byte after bit 3 of 0xFF
    in_valid = 1'b1; in_data = 8'hFF;
    repeat (16) begin @(negedge clk); in_valid = 1'b0; end
    chk("pre_reset_s", 64'(o_s), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", 64'({o_en, o_s, o_data_in, o_done, o_ready}), 64'd0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (3) begin @(negedge clk); if (o_done !== 1'b0) bad = 1'b1; end
    chk("no_done_after_abort", 64'(bad), 64'd0);
    send(8'h3C, 1'b0, 1'b0, acc1);

    // reset wins over a simultaneous handshake
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("reset_priority", 64'({o_en, o_data_in, o_ready}), 64'd0);
    @(negedge clk);
    chk("reset_priority_idle", 64'({o_en, o_ready}), 64'd1);

    // MSB first, then junk on IN_DATA/IN_VALID mid-byte and the 3-cycle gap
    sel = 2'd1;
    send(8'hA5, 1'b0, 1'b0, acc1);
    send(8'hA5, 1'b0, 1'b1, acc1);
    m = 0;
    while (o_ready !== 1'b1 && m < 10) begin
      @(negedge clk);
      m++;
      if (o_en !== 1'b0) bad = 1'b1;
    end
    chk("gap_cycles", 64'(m), 64'd3);
    chk("gap_data_held", 64'(o_data_in), 64'hA5);
    chk("no_extra_accept", 64'(bad), 64'd0);

    // single clock per bit
    sel = 2'd2;
    send(8'h5A, 1'b0, 1'b0, acc1);
    @(negedge clk);
    chk("done_single_pulse3", 64'(o_done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
